// File: rtl/img_pkg.sv
// ============================================================================
// Module : img_pkg
// Brief  : Frame geometry, pixel width, FSM encoding and raster address helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package img_pkg;

  localparam int IMG_W     = 128;
  localparam int IMG_H     = 128;
  localparam int PIX_W     = 8;
  localparam int FRAME_PIX = IMG_W * IMG_H;
  localparam int ADDR_W    = $clog2(FRAME_PIX);
  localparam int COL_W     = $clog2(IMG_W);
  localparam int ROW_W     = $clog2(IMG_H);

  typedef logic [0:0] state_t;
  localparam state_t FILL  = 1'b0;
  localparam state_t DRAIN = 1'b1;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col);
    return ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_buffer_ram.sv
// ============================================================================
// Module : frame_buffer_ram
// Brief  : FRAME_PIX x PIX_W simple dual-port RAM, registered read, no reset.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module frame_buffer_ram
  import img_pkg::*;
(
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [PIX_W-1:0]  i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [PIX_W-1:0]  o_rd_data
);

  logic [PIX_W-1:0] r_mem [FRAME_PIX];
  logic [PIX_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/conv_frame_reader.sv
// ============================================================================
// Module : conv_frame_reader
// Brief  : Captures one raster frame into a buffer, then streams it out over
//          valid/ready through a 2-entry skid.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module conv_frame_reader
  import img_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] in_pixel_data,
  input  logic             in_pixel_valid,
  output logic             in_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_eol,
  output logic             out_last,
  output logic             frame_done,
  output logic             overflow
);

  state_t           r_state, w_state_nxt;
  logic [COL_W-1:0] r_wr_col, r_rd_col;
  logic [ROW_W-1:0] r_wr_row, r_rd_row;
  logic             r_rd_done;
  logic             r_pend, r_pend_eol, r_pend_last;
  logic             r_sp_valid, r_sp_eol, r_sp_last;
  logic [PIX_W-1:0] r_sp_data;
  logic             r_out_valid, r_out_eol, r_out_last;
  logic [PIX_W-1:0] r_out_data;
  logic             r_frame_done, r_overflow;

  logic             w_in_ready, w_drain, w_wr_en;
  logic             w_wr_col_end, w_wr_row_end, w_rd_col_end, w_rd_row_end;
  logic             w_pop, w_out_free, w_last_accept, w_rd_issue;
  logic [1:0]       w_occ;
  logic [PIX_W-1:0] w_rd_data;

  assign w_wr_col_end  = (r_wr_col == COL_W'(IMG_W - 1));
  assign w_wr_row_end  = (r_wr_row == ROW_W'(IMG_H - 1));
  assign w_rd_col_end  = (r_rd_col == COL_W'(IMG_W - 1));
  assign w_rd_row_end  = (r_rd_row == ROW_W'(IMG_H - 1));
  assign w_pop         = r_out_valid & out_ready;
  assign w_out_free    = ~r_out_valid | out_ready;
  assign w_last_accept = w_pop & r_out_last;

  // Credit check: entries held plus the read in flight must fit the 2-entry skid.
  assign w_occ      = {1'b0, r_out_valid} + {1'b0, r_sp_valid} + {1'b0, r_pend};
  assign w_rd_issue = w_drain & ~r_rd_done & ((w_occ - {1'b0, w_pop}) < 2'd2);

  always_ff @(posedge clk) begin
    if (reset) r_state <= FILL;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL:    if (w_wr_en && w_wr_col_end && w_wr_row_end) w_state_nxt = DRAIN;
      DRAIN:   if (w_last_accept) w_state_nxt = FILL;
      default: w_state_nxt = FILL;
    endcase
  end

  always_comb begin
    w_in_ready = (r_state == FILL);
    w_drain    = (r_state == DRAIN);
    w_wr_en    = in_pixel_valid & w_in_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_col <= '0;
      r_wr_row <= '0;
    end else if (w_wr_en) begin
      r_wr_col <= w_wr_col_end ? '0 : r_wr_col + 1'b1;
      if (w_wr_col_end) r_wr_row <= w_wr_row_end ? '0 : r_wr_row + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_col    <= '0;
      r_rd_row    <= '0;
      r_rd_done   <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_eol  <= 1'b0;
      r_pend_last <= 1'b0;
    end else begin
      r_pend      <= w_rd_issue;
      r_pend_eol  <= w_rd_col_end;
      r_pend_last <= w_rd_col_end & w_rd_row_end;
      if (w_rd_issue) begin
        r_rd_col <= w_rd_col_end ? '0 : r_rd_col + 1'b1;
        if (w_rd_col_end) r_rd_row <= w_rd_row_end ? '0 : r_rd_row + 1'b1;
        if (w_rd_col_end && w_rd_row_end) r_rd_done <= 1'b1;
      end
      if (w_last_accept) r_rd_done <= 1'b0;
    end
  end

  // Spare entry only fills when the output register is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_eol   <= 1'b0;
      r_out_last  <= 1'b0;
      r_sp_valid  <= 1'b0;
      r_sp_data   <= '0;
      r_sp_eol    <= 1'b0;
      r_sp_last   <= 1'b0;
    end else if (w_out_free) begin
      if (r_sp_valid) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_sp_data;
        r_out_eol   <= r_sp_eol;
        r_out_last  <= r_sp_last;
        r_sp_valid  <= r_pend;
        r_sp_data   <= w_rd_data;
        r_sp_eol    <= r_pend_eol;
        r_sp_last   <= r_pend_last;
      end else if (r_pend) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_rd_data;
        r_out_eol   <= r_pend_eol;
        r_out_last  <= r_pend_last;
      end else begin
        r_out_valid <= 1'b0;
        r_out_eol   <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end else if (r_pend) begin
      r_sp_valid <= 1'b1;
      r_sp_data  <= w_rd_data;
      r_sp_eol   <= r_pend_eol;
      r_sp_last  <= r_pend_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_frame_done <= w_last_accept;
      if (in_pixel_valid && !w_in_ready) r_overflow <= 1'b1;
    end
  end

  frame_buffer_ram u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (pix_addr(r_wr_row, r_wr_col)),
    .i_wr_data (in_pixel_data),
    .i_rd_en   (w_rd_issue),
    .i_rd_addr (pix_addr(r_rd_row, r_rd_col)),
    .o_rd_data (w_rd_data)
  );

  assign in_ready   = w_in_ready;
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign out_eol    = r_out_eol;
  assign out_last   = r_out_last;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_conv_frame_reader.sv
// ============================================================================
// Module : tb_conv_frame_reader
// Brief  : Directed self-checking bench for conv_frame_reader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_conv_frame_reader;
  import img_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic [PIX_W-1:0] in_pixel_data;
  logic             in_pixel_valid;
  logic             in_ready;
  logic [PIX_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_eol;
  logic             out_last;
  logic             frame_done;
  logic             overflow;

  int vectors     = 0;
  int miscompares = 0;

  conv_frame_reader dut (
    .clk            (clk),
    .reset          (reset),
    .in_pixel_data  (in_pixel_data),
    .in_pixel_valid (in_pixel_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_eol        (out_eol),
    .out_last       (out_last),
    .frame_done     (frame_done),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected beat k: {pixel, eol, last}; flat selects the constant 8'h3C frame.
  function automatic logic [PIX_W+1:0] exp_beat(input int k, input bit flat);
    int r, c;
    logic [PIX_W-1:0] p;
    r = k / IMG_W;
    c = k % IMG_W;
    p = flat ? 8'h3C : 8'((r + c) & 8'hFF);
    return {p, (c == IMG_W - 1), (k == FRAME_PIX - 1)};
  endfunction

  task automatic fill_frame(input bit flat, input bit gaps,
                            output int not_ready, output int out_seen);
    int idx;
    bit v;
    logic [PIX_W+1:0] e;
    idx = 0;
    not_ready = 0;
    out_seen = 0;
    while (idx < FRAME_PIX) begin
      v = (gaps && idx < 512) ? ($urandom_range(9) < 3) : 1'b1;
      e = exp_beat(idx, flat);
      in_pixel_valid = v;
      in_pixel_data  = v ? e[PIX_W+1:2] : 8'hAA;
      if (in_ready !== 1'b1) not_ready++;
      if (out_valid !== 1'b0) out_seen++;
      step();
      if (v) idx++;
    end
    in_pixel_valid = 1'b0;
    in_pixel_data  = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_pixel_valid = 1'b0;
    in_pixel_data = '0;
    out_ready = 1'b0;
    repeat (3) step();
    vectors++;
    if ({in_ready, out_valid, overflow, frame_done, out_eol, out_last, out_data} !== {6'b100000, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_state: got rdy=%b vld=%b ovf=%b done=%b eol=%b last=%b data=%h, want 1 0 0 0 0 0 00",
               in_ready, out_valid, overflow, frame_done, out_eol, out_last, out_data);
    end
    reset = 1'b0;
    step();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_full_frame();
    int nr, os, n, gaps_seen, done_seen;
    logic [PIX_W+1:0] e;
    out_ready = 1'b1;
    fill_frame(1'b0, 1'b0, nr, os);
    vectors++;
    if (nr != 0 || os != 0) begin
      miscompares++;
      $display("FAIL fill_handshake: not_ready=%0d out_valid_seen=%0d, want 0 0", nr, os);
    end
    vectors++;
    if (in_ready !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_entry: in_ready=%b overflow=%b, want 0 0", in_ready, overflow);
    end
    n = 0;
    while (out_valid !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    vectors++;
    if (n != 2) begin
      miscompares++;
      $display("FAIL first_valid_latency: got %0d cycles, want 2", n);
    end
    gaps_seen = 0;
    done_seen = 0;
    for (int k = 0; k < FRAME_PIX; k++) begin
      e = exp_beat(k, 1'b0);
      if (out_valid !== 1'b1) gaps_seen++;
      if (frame_done !== 1'b0) done_seen++;
      vectors++;
      if ({out_data, out_eol, out_last} !== e) begin
        miscompares++;
        $display("FAIL full_beat %0d: got data=%h eol=%b last=%b, want data=%h eol=%b last=%b",
                 k, out_data, out_eol, out_last, e[PIX_W+1:2], e[1], e[0]);
      end
      in_pixel_valid = ((k >= 200 && k <= 203) || k == FRAME_PIX - 1);
      in_pixel_data  = 8'hAA;
      step();
    end
    in_pixel_valid = 1'b0;
    vectors++;
    if (gaps_seen != 0 || done_seen != 0) begin
      miscompares++;
      $display("FAIL full_throughput: idle beats=%0d early frame_done=%0d, want 0 0", gaps_seen, done_seen);
    end
    vectors++;
    if ({frame_done, in_ready, out_valid, overflow} !== 4'b1101) begin
      miscompares++;
      $display("FAIL frame_end: done=%b rdy=%b vld=%b ovf=%b, want 1 1 0 1",
               frame_done, in_ready, out_valid, overflow);
    end
    step();
    vectors++;
    if (frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_done_pulse: got %b one cycle later, want 0", frame_done);
    end
  endtask

  task automatic test_backpressure_gaps();
    int nr, os, k, cyc;
    bit rdy, held_v;
    logic [PIX_W+2:0] held;
    logic [PIX_W+1:0] e;
    fill_frame(1'b0, 1'b1, nr, os);
    vectors++;
    if (nr != 0 || os != 0) begin
      miscompares++;
      $display("FAIL gap_fill_handshake: not_ready=%0d out_valid_seen=%0d, want 0 0", nr, os);
    end
    k = 0;
    cyc = 0;
    held_v = 1'b0;
    held = '0;
    while (k < 5000 && cyc < 20000) begin
      if (held_v) begin
        vectors++;
        if ({out_valid, out_data, out_eol, out_last} !== held) begin
          miscompares++;
          $display("FAIL stall_hold at beat %0d: got vld=%b data=%h eol=%b last=%b, want %b %h %b %b",
                   k, out_valid, out_data, out_eol, out_last,
                   held[PIX_W+2], held[PIX_W+1:2], held[1], held[0]);
        end
      end
      rdy = (k < 3000) ? 1'($urandom_range(1)) : 1'b1;
      out_ready = rdy;
      held_v = 1'b0;
      if (out_valid === 1'b1) begin
        if (rdy) begin
          e = exp_beat(k, 1'b0);
          vectors++;
          if ({out_data, out_eol, out_last} !== e) begin
            miscompares++;
            $display("FAIL bp_beat %0d: got data=%h eol=%b last=%b, want data=%h eol=%b last=%b",
                     k, out_data, out_eol, out_last, e[PIX_W+1:2], e[1], e[0]);
          end
          k++;
        end else begin
          held_v = 1'b1;
          held = {1'b1, out_data, out_eol, out_last};
        end
      end
      step();
      cyc++;
    end
    vectors++;
    if (k != 5000) begin
      miscompares++;
      $display("FAIL bp_timeout: %0d beats accepted in %0d cycles, want 5000", k, cyc);
    end
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_sticky: got %b, want 1", overflow);
    end
  endtask

  task automatic test_reset_mid_drain();
    int vseen;
    out_ready = 1'b0;
    reset = 1'b1;
    step();
    vectors++;
    if ({in_ready, out_valid, overflow, frame_done, out_eol, out_last, out_data} !== {6'b100000, 8'h00}) begin
      miscompares++;
      $display("FAIL mid_drain_reset: got rdy=%b vld=%b ovf=%b done=%b eol=%b last=%b data=%h, want 1 0 0 0 0 0 00",
               in_ready, out_valid, overflow, frame_done, out_eol, out_last, out_data);
    end
    reset = 1'b0;
    out_ready = 1'b1;
    vseen = 0;
    repeat (4) begin
      step();
      if (out_valid !== 1'b0 || in_ready !== 1'b1) vseen++;
    end
    vectors++;
    if (vseen != 0) begin
      miscompares++;
      $display("FAIL post_abort_idle: %0d cycles with output activity or in_ready low, want 0", vseen);
    end
  endtask

  task automatic test_new_frame();
    int nr, os, n, idle;
    logic [PIX_W+1:0] e;
    out_ready = 1'b1;
    fill_frame(1'b1, 1'b0, nr, os);
    vectors++;
    if (nr != 0 || os != 0) begin
      miscompares++;
      $display("FAIL flat_fill_handshake: not_ready=%0d out_valid_seen=%0d, want 0 0", nr, os);
    end
    n = 0;
    while (out_valid !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    vectors++;
    if (n != 2) begin
      miscompares++;
      $display("FAIL flat_first_valid: got %0d cycles, want 2", n);
    end
    idle = 0;
    for (int k = 0; k < FRAME_PIX; k++) begin
      e = exp_beat(k, 1'b1);
      if (out_valid !== 1'b1) idle++;
      vectors++;
      if ({out_data, out_eol, out_last} !== e) begin
        miscompares++;
        $display("FAIL flat_beat %0d: got data=%h eol=%b last=%b, want data=%h eol=%b last=%b",
                 k, out_data, out_eol, out_last, e[PIX_W+1:2], e[1], e[0]);
      end
      step();
    end
    vectors++;
    if (idle != 0 || frame_done !== 1'b1 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL flat_frame_end: idle=%0d done=%b ovf=%b, want 0 1 0", idle, frame_done, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure_gaps();
    test_reset_mid_drain();
    test_new_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
